// File: rtl/complex_mult_scoreboard_pkg.sv
// Shared definitions for the complex multiplier scoreboard:
// operand/result field positions and the saturating counter helper.
package complex_mult_scoreboard_pkg;

    // Operand field index within op_data, in units of DATA_WIDTH (a_re in MSBs)
    localparam int unsigned OP_A_RE = 3;
    localparam int unsigned OP_A_IM = 2;
    localparam int unsigned OP_B_RE = 1;
    localparam int unsigned OP_B_IM = 0;

    // Result field index within res_data, in units of 2*DATA_WIDTH (re in MSBs)
    localparam int unsigned RES_RE = 1;
    localparam int unsigned RES_IM = 0;

    // Increment a counter of width w (w <= 32), holding at all-ones
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/complex_mult_scoreboard_scb_fifo.sv
// scb_fifo: in-order queue of expected results with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// the caller is responsible for gating push accordingly.
module scb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // Pointer and occupancy next state; pointers wrap naturally (DEPTH is 2^AW)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates validity
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/complex_mult_scoreboard.sv
// complex_mult_scoreboard: passive checker for the complex multiplier.
// Queues expected products of accepted operands and compares each accepted
// result against the oldest expectation. Optional watchdog: SCB_TIMEOUT_EN.
module complex_mult_scoreboard
    import complex_mult_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SIGNED_MODE = 0,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      sw_rst,
    input  logic                      op_val,
    input  logic                      op_ready,
    input  logic [4*DATA_WIDTH-1:0]   op_data,
    input  logic                      res_val,
    input  logic                      res_ready,
    input  logic [4*DATA_WIDTH-1:0]   res_data,
    output logic [CNT_WIDTH-1:0]      pass_cnt,
    output logic [CNT_WIDTH-1:0]      fail_cnt,
    output logic [CNT_WIDTH-1:0]      unexp_cnt,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      overflow,
    output logic                      mismatch,
    output logic                      timeout
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned RW = 2 * DATA_WIDTH;

    typedef struct packed {
        logic [RW-1:0] re;
        logic [RW-1:0] im;
    } exp_entry_t;

    logic          push_hs, pop_hs, do_push, do_pop, ovf_ev, match;
    logic          fifo_full, fifo_empty;
    logic [4*DW-1:0] fifo_dout;
    exp_entry_t    exp_e, head_e;
    logic [RW-1:0] a_re_x, a_im_x, b_re_x, b_im_x;
    logic [RW-1:0] p_rr, p_ii, p_ri, p_ir;

    logic [CNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d, unexp_q, unexp_d;
    logic                 overflow_q, overflow_d, mismatch_q, mismatch_d;

    assign push_hs = op_val && op_ready;
    assign pop_hs  = res_val && res_ready;
    // No bypass: a result arriving while empty is unexpected even if an op lands too
    assign do_pop  = pop_hs && !fifo_empty;
    assign do_push = push_hs && (!fifo_full || do_pop);
    assign ovf_ev  = push_hs && fifo_full && !do_pop;

    // Expected product: extend components to 2*DW, all arithmetic modulo 2^(2*DW)
    always_comb begin
        if (SIGNED_MODE != 0) begin
            a_re_x = {{DW{op_data[OP_A_RE*DW+DW-1]}}, op_data[OP_A_RE*DW +: DW]};
            a_im_x = {{DW{op_data[OP_A_IM*DW+DW-1]}}, op_data[OP_A_IM*DW +: DW]};
            b_re_x = {{DW{op_data[OP_B_RE*DW+DW-1]}}, op_data[OP_B_RE*DW +: DW]};
            b_im_x = {{DW{op_data[OP_B_IM*DW+DW-1]}}, op_data[OP_B_IM*DW +: DW]};
        end else begin
            a_re_x = {{DW{1'b0}}, op_data[OP_A_RE*DW +: DW]};
            a_im_x = {{DW{1'b0}}, op_data[OP_A_IM*DW +: DW]};
            b_re_x = {{DW{1'b0}}, op_data[OP_B_RE*DW +: DW]};
            b_im_x = {{DW{1'b0}}, op_data[OP_B_IM*DW +: DW]};
        end
        p_rr     = a_re_x * b_re_x;
        p_ii     = a_im_x * b_im_x;
        p_ri     = a_re_x * b_im_x;
        p_ir     = a_im_x * b_re_x;
        exp_e.re = p_rr - p_ii;
        exp_e.im = p_ri + p_ir;
    end

    scb_fifo #(
        .WIDTH (4*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (sw_rst),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .din_i   (exp_e),
        .dout_o  (fifo_dout),
        .count_o (pending),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_e = fifo_dout;
    assign match  = (res_data[RES_RE*RW +: RW] == head_e.re) &&
                    (res_data[RES_IM*RW +: RW] == head_e.im);

    // Statistics, sticky overflow and mismatch pulse next state
    always_comb begin
        pass_d     = pass_q;
        fail_d     = fail_q;
        unexp_d    = unexp_q;
        overflow_d = overflow_q | ovf_ev;
        mismatch_d = do_pop && !match;
        if (do_pop) begin
            if (match) pass_d = CNT_WIDTH'(sat_inc(32'(pass_q), CNT_WIDTH));
            else       fail_d = CNT_WIDTH'(sat_inc(32'(fail_q), CNT_WIDTH));
        end
        if (pop_hs && fifo_empty) unexp_d = CNT_WIDTH'(sat_inc(32'(unexp_q), CNT_WIDTH));
    end

    // Statistics registers; reset wins over any same-cycle event
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            pass_q     <= '0;
            fail_q     <= '0;
            unexp_q    <= '0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            unexp_q    <= unexp_d;
            overflow_q <= overflow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign unexp_cnt = unexp_q;
    assign overflow  = overflow_q;
    assign mismatch  = mismatch_q;

`ifdef SCB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;

    // Idle counter runs while expectations wait without a result handshake
    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (pop_hs || fifo_empty)          idle_d = '0;
        else if (idle_q != TW'(TIMEOUT))   idle_d = idle_q + 1'b1;
        if (idle_d == TW'(TIMEOUT))        timeout_d = 1'b1;
    end

    // Watchdog registers; timeout stays set until reset
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_complex_mult_scoreboard.sv
// Directed bench for complex_mult_scoreboard: an unsigned and a signed
// instance see the same stimulus; expected values are hand-computed.
module tb_complex_mult_scoreboard;

    logic        clk = 1'b0;
    logic        sw_rst, op_val, op_ready, res_val, res_ready;
    logic [31:0] op_data, res_data;

    logic [15:0] pass_u, fail_u, unexp_u, pass_s, fail_s, unexp_s;
    logic [2:0]  pend_u, pend_s;
    logic        ovf_u, mis_u, to_u, ovf_s, mis_s, to_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    complex_mult_scoreboard #(
        .DATA_WIDTH (8), .DEPTH (4), .SIGNED_MODE (0), .CNT_WIDTH (16), .TIMEOUT (64)
    ) u_dut (
        .clk (clk), .sw_rst (sw_rst),
        .op_val (op_val), .op_ready (op_ready), .op_data (op_data),
        .res_val (res_val), .res_ready (res_ready), .res_data (res_data),
        .pass_cnt (pass_u), .fail_cnt (fail_u), .unexp_cnt (unexp_u),
        .pending (pend_u), .overflow (ovf_u), .mismatch (mis_u), .timeout (to_u)
    );

    complex_mult_scoreboard #(
        .DATA_WIDTH (8), .DEPTH (4), .SIGNED_MODE (1), .CNT_WIDTH (16), .TIMEOUT (64)
    ) u_dut_s (
        .clk (clk), .sw_rst (sw_rst),
        .op_val (op_val), .op_ready (op_ready), .op_data (op_data),
        .res_val (res_val), .res_ready (res_ready), .res_data (res_data),
        .pass_cnt (pass_s), .fail_cnt (fail_s), .unexp_cnt (unexp_s),
        .pending (pend_s), .overflow (ovf_s), .mismatch (mis_s), .timeout (to_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus, then all valids drop
    task automatic cyc(input logic ov, input logic [31:0] od, input logic rv, input logic [31:0] rd);
        op_val   = ov;
        op_data  = od;
        res_val  = rv;
        res_data = rd;
        tick();
        op_val  = 1'b0;
        res_val = 1'b0;
    endtask

    task automatic do_reset();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
    endtask

    initial begin
        sw_rst = 1'b1; op_val = 1'b0; op_ready = 1'b1; res_val = 1'b0; res_ready = 1'b1;
        op_data = '0; res_data = '0;
        tick(); tick();
        sw_rst = 1'b0;

        // Reset state
        chk("rst_pass", 32'(pass_u), 0);
        chk("rst_pending", 32'(pend_u), 0);
        chk("rst_overflow", 32'(ovf_u), 0);
        chk("rst_mismatch", 32'(mis_u), 0);
        chk("rst_timeout", 32'(to_u), 0);

        // (3+2i)*(1+4i) = -5 + 14i, result 3 cycles after the op
        cyc(1'b1, 32'h03020104, 1'b0, '0);
        chk("t1_pending_push", 32'(pend_u), 1);
        tick(); tick();
        cyc(1'b0, '0, 1'b1, 32'hFFFB000E);
        chk("t1_pass", 32'(pass_u), 1);
        chk("t1_pending_pop", 32'(pend_u), 0);
        chk("t1_no_mismatch", 32'(mis_u), 0);

        // Valid without ready is not a push
        op_ready = 1'b0;
        cyc(1'b1, 32'h01010101, 1'b0, '0);
        op_ready = 1'b1;
        chk("t1_noready", 32'(pend_u), 0);

        // {FF,01,02,03}: signed expects {FFFB,FFFF}, unsigned expects {01FB,02FF}
        cyc(1'b1, 32'hFF010203, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 32'hFFFBFFFF);
        chk("t2_u_fail", 32'(fail_u), 1);
        chk("t2_u_mismatch", 32'(mis_u), 1);
        chk("t2_s_pass", 32'(pass_s), 2);
        chk("t2_s_no_mismatch", 32'(mis_s), 0);
        tick();
        chk("t2_u_pulse_end", 32'(mis_u), 0);
        cyc(1'b1, 32'hFF010203, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 32'h01FB02FF);
        chk("t2_u_pass", 32'(pass_u), 2);
        chk("t2_s_fail", 32'(fail_s), 1);
        chk("t2_s_mismatch", 32'(mis_s), 1);
        // re wrong by one in both modes
        cyc(1'b1, 32'hFF010203, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 32'h01FC02FF);
        chk("t2_u_fail_re", 32'(fail_u), 2);
        chk("t2_u_pass_hold", 32'(pass_u), 2);
        chk("t2_u_mismatch_re", 32'(mis_u), 1);
        tick();
        chk("t2_u_pulse_end2", 32'(mis_u), 0);

        // Five pushes without results: (k+0i)*(1+0i) = k
        do_reset();
        for (int k = 1; k <= 5; k++) cyc(1'b1, {8'(k), 8'h00, 8'h01, 8'h00}, 1'b0, '0);
        chk("t3_pending_full", 32'(pend_u), 4);
        chk("t3_overflow", 32'(ovf_u), 1);
        for (int k = 1; k <= 4; k++) cyc(1'b0, '0, 1'b1, {16'(k), 16'h0000});
        chk("t3_pass", 32'(pass_u), 4);
        chk("t3_fail", 32'(fail_u), 0);
        chk("t3_pending_empty", 32'(pend_u), 0);

        // Full with simultaneous push and pop: no overflow
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(1'b1, {8'(k), 8'h00, 8'h01, 8'h00}, 1'b0, '0);
        cyc(1'b1, {8'd5, 8'h00, 8'h01, 8'h00}, 1'b1, {16'd1, 16'h0000});
        chk("t3b_no_overflow", 32'(ovf_u), 0);
        chk("t3b_pending", 32'(pend_u), 4);
        chk("t3b_pass", 32'(pass_u), 1);
        for (int k = 2; k <= 5; k++) cyc(1'b0, '0, 1'b1, {16'(k), 16'h0000});
        chk("t3b_drain", 32'(pass_u), 5);

        // Back-to-back push+pop at pending=2 for 20 cycles
        do_reset();
        cyc(1'b1, {8'd1, 8'h00, 8'h01, 8'h00}, 1'b0, '0);
        cyc(1'b1, {8'd2, 8'h00, 8'h01, 8'h00}, 1'b0, '0);
        for (int j = 1; j <= 20; j++)
            cyc(1'b1, {8'(j + 2), 8'h00, 8'h01, 8'h00}, 1'b1, {16'(j), 16'h0000});
        chk("t4_pending", 32'(pend_u), 2);
        chk("t4_pass", 32'(pass_u), 20);
        chk("t4_fail", 32'(fail_u), 0);
        cyc(1'b0, '0, 1'b1, {16'd21, 16'h0000});
        cyc(1'b0, '0, 1'b1, {16'd22, 16'h0000});
        chk("t4_drain", 32'(pass_u), 22);

        // Unexpected results: empty queue, then same cycle as the first op
        do_reset();
        cyc(1'b0, '0, 1'b1, 32'h00010000);
        chk("t5_unexp1", 32'(unexp_u), 1);
        chk("t5_pending0", 32'(pend_u), 0);
        cyc(1'b1, 32'h03020104, 1'b1, 32'hFFFB000E);
        chk("t5_unexp2", 32'(unexp_u), 2);
        chk("t5_pending1", 32'(pend_u), 1);
        chk("t5_no_pass", 32'(pass_u), 0);

        // Watchdog: one expectation outstanding for 70 cycles
        for (int i = 0; i < 70; i++) tick();
`ifdef SCB_TIMEOUT_EN
        chk("t6_timeout", 32'(to_u), 1);
`else
        chk("t6_timeout_off", 32'(to_u), 0);
`endif

        // Reset mid-queue clears everything
        do_reset();
        chk("t6_rst_pending", 32'(pend_u), 0);
        chk("t6_rst_unexp", 32'(unexp_u), 0);
        chk("t6_rst_timeout", 32'(to_u), 0);
        chk("t6_rst_overflow", 32'(ovf_u), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
